// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle from vga_timing_gen to its consumers (color_mapper, DAC pins).
// The master modport drives everything; consumers take the slave modport.
interface vga_timing_gen_if;
  logic       pixel_tick;
  logic       hs;
  logic       vs;
  logic       blank_n;
  logic       sync_n;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output pixel_tick, hs, vs, blank_n, sync_n,
    output DrawX, DrawY, line_start, frame_start, frame_count
  );

  modport slave (
    input pixel_tick, hs, vs, blank_n, sync_n,
    input DrawX, DrawY, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA raster timing from the 50 MHz clock (pixel rate = Clk / CLK_DIV).
// Optional PIXEL_LEAD_EN: hs/vs/blank_n lag DrawX/DrawY by one pixel to cover RAM read latency.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic              Clk,
  input  logic              Reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_next;
  logic             r_pixel_tick;
  logic             w_tick_next;

  logic [9:0]       r_draw_x;
  logic [9:0]       r_draw_y;
  logic [9:0]       w_x_next;
  logic [9:0]       w_y_next;
  logic             w_x_wrap;
  logic             w_y_wrap;

  logic             r_line_start;
  logic             r_frame_start;
  logic [7:0]       r_frame_count;

  // Bit order {hs, vs, blank_n}; these track the counters with zero latency.
  logic [2:0]       r_sync_aligned;
  logic [2:0]       w_sync_next;
  logic [2:0]       w_sync_out;

  always_comb begin
    w_div_next = (r_div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : r_div_cnt + DIV_W'(1);
    // Tick is registered but reflects the divider value it is stored alongside.
    w_tick_next = (w_div_next == DIV_W'(CLK_DIV - 1));
  end

  always_comb begin
    w_x_wrap = r_pixel_tick && (r_draw_x == 10'(H_TOTAL - 1));
    w_y_wrap = w_x_wrap && (r_draw_y == 10'(V_TOTAL - 1));
    w_x_next = r_draw_x;
    w_y_next = r_draw_y;
    if (r_pixel_tick) begin
      if (w_x_wrap) begin
        w_x_next = '0;
        w_y_next = w_y_wrap ? 10'd0 : r_draw_y + 10'd1;
      end else begin
        w_x_next = r_draw_x + 10'd1;
      end
    end
  end

  // Decoding the next counter values keeps sync/blank in step with DrawX/DrawY.
  always_comb begin
    w_sync_next[2] = !((w_x_next >= 10'(H_SYNC_START)) && (w_x_next < 10'(H_SYNC_END)));
    w_sync_next[1] = !((w_y_next >= 10'(V_SYNC_START)) && (w_y_next < 10'(V_SYNC_END)));
    w_sync_next[0] = (w_x_next < 10'(H_VISIBLE)) && (w_y_next < 10'(V_VISIBLE));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div_cnt      <= '0;
      r_pixel_tick   <= 1'b0;
      r_draw_x       <= '0;
      r_draw_y       <= '0;
      r_line_start   <= 1'b0;
      r_frame_start  <= 1'b0;
      r_frame_count  <= '0;
      r_sync_aligned <= 3'b111;
    end else begin
      r_div_cnt      <= w_div_next;
      r_pixel_tick   <= w_tick_next;
      r_draw_x       <= w_x_next;
      r_draw_y       <= w_y_next;
      r_line_start   <= w_x_wrap;
      r_frame_start  <= w_y_wrap;
      r_sync_aligned <= w_sync_next;
      if (w_y_wrap) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

`ifdef PIXEL_LEAD_EN
  // Delayed copies start blanked with syncs inactive; each captures on the pixel edge.
  localparam logic [2:0] LEAD_RST = 3'b110;
  logic [2:0] r_sync_lead;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lead
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_sync_lead[gi] <= LEAD_RST[gi];
        end else if (r_pixel_tick) begin
          r_sync_lead[gi] <= r_sync_aligned[gi];
        end
      end
    end
  endgenerate

  assign w_sync_out = r_sync_lead;
`else
  assign w_sync_out = r_sync_aligned;
`endif

  assign vga.pixel_tick  = r_pixel_tick;
  assign vga.hs          = w_sync_out[2];
  assign vga.vs          = w_sync_out[1];
  assign vga.blank_n     = w_sync_out[0];
  assign vga.sync_n      = 1'b0;
  assign vga.DrawX       = r_draw_x;
  assign vga.DrawY       = r_draw_y;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;
  assign vga.frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line timing and mid-frame reset, plus a
// shrunken-raster instance (8x5) so frame strobes and the 255->0 wrap are reachable.
module tb_vga_timing_gen;

`ifdef PIXEL_LEAD_EN
  localparam bit LEAD = 1'b1;
`else
  localparam bit LEAD = 1'b0;
`endif

  logic Clk;
  logic Reset;
  logic Reset_s;

  int errors = 0;
  int checks = 0;
  int k_a    = 0;  // Clk edges since big-instance reset release
  int k_b    = 0;  // Clk edges since small-instance reset release
  int ls_a   = 0;
  int fs_a   = 0;
  int fs_b   = 0;
  int ls_mark;
  int fs_mark;

  vga_timing_gen_if va ();
  vga_timing_gen_if vb ();

  vga_timing_gen u_dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .vga   (va)
  );

  vga_timing_gen #(
    .CLK_DIV   (2),
    .H_VISIBLE (4),
    .H_FRONT   (1),
    .H_SYNC    (2),
    .H_BACK    (1),
    .V_VISIBLE (2),
    .V_FRONT   (1),
    .V_SYNC    (1),
    .V_BACK    (1)
  ) u_dut_b (
    .Clk   (Clk),
    .Reset (Reset_s),
    .vga   (vb)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge and tallying strobes.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      k_a++;
      k_b++;
      if (va.line_start === 1'b1) ls_a++;
      if (va.frame_start === 1'b1) fs_a++;
      if (vb.frame_start === 1'b1) fs_b++;
    end
  endtask

  task automatic goto_a(input int k);
    adv(k - k_a);
  endtask

  task automatic goto_b(input int k);
    adv(k - k_b);
  endtask

  initial begin
    Reset   = 1'b1;
    Reset_s = 1'b1;
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    k_a   = 0;
    ls_a  = 0;
    fs_a  = 0;

    // Reset state
    chk("rst_drawx",  32'(va.DrawX), 0);
    chk("rst_drawy",  32'(va.DrawY), 0);
    chk("rst_hs",     32'(va.hs), 1);
    chk("rst_vs",     32'(va.vs), 1);
    chk("rst_blank",  32'(va.blank_n), LEAD ? 0 : 1);
    chk("rst_tick",   32'(va.pixel_tick), 0);
    chk("rst_ls",     32'(va.line_start), 0);
    chk("rst_fs",     32'(va.frame_start), 0);
    chk("rst_fc",     32'(va.frame_count), 0);
    chk("sync_n",     32'(va.sync_n), 0);

    // Divider: tick on the second cycle, DrawX=1 after it
    goto_a(1);
    chk("k1_tick",  32'(va.pixel_tick), 1);
    chk("k1_drawx", 32'(va.DrawX), 0);
    goto_a(2);
    chk("k2_tick",  32'(va.pixel_tick), 0);
    chk("k2_drawx", 32'(va.DrawX), 1);

    // Horizontal blank edge at DrawX=640
    goto_a(1279);
    chk("x639_drawx", 32'(va.DrawX), 639);
    chk("x639_blank", 32'(va.blank_n), 1);
    goto_a(1280);
    chk("x640_drawx", 32'(va.DrawX), 640);
    chk("x640_blank", 32'(va.blank_n), LEAD ? 1 : 0);
    goto_a(1282);
    chk("x641_blank", 32'(va.blank_n), 0);

    // hsync window [656,751]
    goto_a(1310);
    chk("x655_hs", 32'(va.hs), 1);
    goto_a(1312);
    chk("x656_drawx", 32'(va.DrawX), 656);
    chk("x656_hs",    32'(va.hs), LEAD ? 1 : 0);
    goto_a(1314);
    chk("x657_hs", 32'(va.hs), 0);
    goto_a(1504);
    chk("x752_drawx", 32'(va.DrawX), 752);
    chk("x752_hs",    32'(va.hs), LEAD ? 0 : 1);
    goto_a(1506);
    chk("x753_hs", 32'(va.hs), 1);

    // End of line 0 and line_start
    goto_a(1599);
    chk("x799_drawx", 32'(va.DrawX), 799);
    chk("x799_tick",  32'(va.pixel_tick), 1);
    chk("x799_ls",    32'(va.line_start), 0);
    goto_a(1600);
    chk("line1_drawx", 32'(va.DrawX), 0);
    chk("line1_drawy", 32'(va.DrawY), 1);
    chk("line1_ls",    32'(va.line_start), 1);
    chk("line1_fs",    32'(va.frame_start), 0);
    chk("line1_vs",    32'(va.vs), 1);
    chk("line1_lscnt", 32'(ls_a), 1);
    goto_a(1601);
    chk("line1_ls_off", 32'(va.line_start), 0);
    goto_a(3200);
    chk("line2_drawy", 32'(va.DrawY), 2);
    chk("line2_ls",    32'(va.line_start), 1);
    chk("line2_lscnt", 32'(ls_a), 2);

    // Mid-frame reset at DrawX=300
    goto_a(3800);
    chk("mid_drawx", 32'(va.DrawX), 300);
    chk("mid_drawy", 32'(va.DrawY), 2);
    chk("mid_blank", 32'(va.blank_n), 1);
    Reset   = 1'b1;
    ls_mark = ls_a;
    fs_mark = fs_a;
    adv(1);
    Reset = 1'b0;
    k_a   = 0;
    chk("mrst_drawx", 32'(va.DrawX), 0);
    chk("mrst_drawy", 32'(va.DrawY), 0);
    chk("mrst_hs",    32'(va.hs), 1);
    chk("mrst_vs",    32'(va.vs), 1);
    chk("mrst_blank", 32'(va.blank_n), LEAD ? 0 : 1);
    chk("mrst_tick",  32'(va.pixel_tick), 0);
    chk("mrst_ls",    32'(va.line_start), 0);
    chk("mrst_fs",    32'(va.frame_start), 0);
    chk("mrst_fc",    32'(va.frame_count), 0);
    chk("mrst_lscnt", 32'(ls_a - ls_mark), 0);
    chk("mrst_fscnt", 32'(fs_a - fs_mark), 0);
    goto_a(2);
    chk("mrst_restart_x", 32'(va.DrawX), 1);

    // Small raster: 8 px/line, 5 lines/frame, 80 Clk/frame; vsync on line 3
    Reset_s = 1'b0;
    k_b     = 0;
    fs_b    = 0;
    chk("s_rst_fc", 32'(vb.frame_count), 0);
    goto_b(47);
    chk("s_y2_drawy", 32'(vb.DrawY), 2);
    chk("s_y2_vs",    32'(vb.vs), 1);
    goto_b(48);
    chk("s_y3_drawy", 32'(vb.DrawY), 3);
    chk("s_y3_vs",    32'(vb.vs), LEAD ? 1 : 0);
    chk("s_y3_ls",    32'(vb.line_start), 1);
    goto_b(50);
    chk("s_y3b_vs", 32'(vb.vs), 0);
    goto_b(64);
    chk("s_y4_drawy", 32'(vb.DrawY), 4);
    chk("s_y4_vs",    32'(vb.vs), LEAD ? 0 : 1);
    goto_b(66);
    chk("s_y4b_vs", 32'(vb.vs), 1);

    goto_b(79);
    chk("s_f0_end_fs", 32'(vb.frame_start), 0);
    chk("s_f0_end_fc", 32'(vb.frame_count), 0);
    goto_b(80);
    chk("s_f1_fs",    32'(vb.frame_start), 1);
    chk("s_f1_ls",    32'(vb.line_start), 1);
    chk("s_f1_fc",    32'(vb.frame_count), 1);
    chk("s_f1_drawx", 32'(vb.DrawX), 0);
    chk("s_f1_drawy", 32'(vb.DrawY), 0);
    chk("s_f1_fscnt", 32'(fs_b), 1);
    goto_b(81);
    chk("s_f1_fs_off", 32'(vb.frame_start), 0);
    chk("s_f1_fc_hold", 32'(vb.frame_count), 1);

    // frame_count wrap after 256 frames
    goto_b(20479);
    chk("s_pre_wrap_fc", 32'(vb.frame_count), 255);
    chk("s_pre_wrap_fs", 32'(vb.frame_start), 0);
    goto_b(20480);
    chk("s_wrap_fc",    32'(vb.frame_count), 0);
    chk("s_wrap_fs",    32'(vb.frame_start), 1);
    chk("s_wrap_drawx", 32'(vb.DrawX), 0);
    chk("s_wrap_drawy", 32'(vb.DrawY), 0);
    chk("s_wrap_hs",    32'(vb.hs), 1);
    chk("s_wrap_vs",    32'(vb.vs), 1);
    chk("s_wrap_blank", 32'(vb.blank_n), LEAD ? 0 : 1);
    chk("s_wrap_fscnt", 32'(fs_b), 256);
    goto_b(20482);
    chk("s_wrap_blank2", 32'(vb.blank_n), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
